// File: rtl/branch_unit_pkg.sv
// Shared branch-code and ALU flag definitions used by the ALU, decoder and branch unit.
package jmp_defs;

    localparam int JMP_TYPE_W = 5;

    localparam logic [JMP_TYPE_W-1:0] JMP_FORCE = 5'd0;
    localparam logic [JMP_TYPE_W-1:0] JMP_E     = 5'd1;
    localparam logic [JMP_TYPE_W-1:0] JMP_NE    = 5'd2;
    localparam logic [JMP_TYPE_W-1:0] JMP_A     = 5'd3;
    localparam logic [JMP_TYPE_W-1:0] JMP_AE    = 5'd4;
    localparam logic [JMP_TYPE_W-1:0] JMP_B     = 5'd5;
    localparam logic [JMP_TYPE_W-1:0] JMP_BE    = 5'd6;
    localparam logic [JMP_TYPE_W-1:0] JMP_G     = 5'd7;
    localparam logic [JMP_TYPE_W-1:0] JMP_GE    = 5'd8;
    localparam logic [JMP_TYPE_W-1:0] JMP_L     = 5'd9;
    localparam logic [JMP_TYPE_W-1:0] JMP_LE    = 5'd10;
    localparam logic [JMP_TYPE_W-1:0] JMP_S     = 5'd11;
    localparam logic [JMP_TYPE_W-1:0] JMP_NS    = 5'd12;
    localparam logic [JMP_TYPE_W-1:0] JMP_O     = 5'd13;
    localparam logic [JMP_TYPE_W-1:0] JMP_NO    = 5'd14;
    localparam logic [JMP_TYPE_W-1:0] JMP_CRZ   = 5'd15;
    localparam logic [JMP_TYPE_W-1:0] JMP_CRNZ  = 5'd16;
    localparam logic [JMP_TYPE_W-1:0] JMP_LOOP  = 5'd17;
    localparam logic [JMP_TYPE_W-1:0] JMP_CALL  = 5'd18;
    localparam logic [JMP_TYPE_W-1:0] JMP_RET   = 5'd19;

    // Bit positions inside the 16-bit ALU flag word (x86 layout).
    localparam int ALUF_CF = 0;
    localparam int ALUF_ZF = 6;
    localparam int ALUF_SF = 7;
    localparam int ALUF_OF = 11;

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_e;

endpackage

// File: rtl/branch_unit_ret_stack.sv
// LIFO of return addresses; the caller guarantees push/pop are legal.
module ret_stack #(
    parameter int AW    = 16,
    parameter int DEPTH = 4,
    localparam int SPW  = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [AW-1:0] din,
    output logic [AW-1:0] dout,
    output logic          full,
    output logic          empty,
    output logic [SPW-1:0] sp
);

    localparam logic [SPW-2:0] IDX_ONE = 1;

    logic [AW-1:0]  mem [DEPTH];
    logic [SPW-1:0] sp_q;
    logic [SPW-2:0] wr_idx;
    logic [SPW-2:0] top_idx;

    assign wr_idx  = sp_q[SPW-2:0];
    // When full the low bits wrap to 0, so top_idx still lands on DEPTH-1.
    assign top_idx = sp_q[SPW-2:0] - IDX_ONE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp_q <= '0;
        end else if (push) begin
            sp_q <= sp_q + SPW'(1);
        end else if (pop) begin
            sp_q <= sp_q - SPW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_idx] <= din;
        end
    end

    assign dout  = mem[top_idx];
    assign full  = (sp_q == SPW'(DEPTH));
    assign empty = (sp_q == '0);
    assign sp    = sp_q;

endmodule

// File: rtl/branch_unit.sv
// Registered branch resolver: flag/count-register conditions, hardware loop counter,
// call/return stack and per-response fault reporting, one-cycle latency.
module branch_unit
    import jmp_defs::*;
#(
    parameter int AW    = 16,
    parameter int DW    = 16,
    parameter int DEPTH = 4,
    localparam int SPW  = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [JMP_TYPE_W-1:0] br_type,
    input  logic [AW-1:0]         target,
    input  logic [AW-1:0]         pc_i,
    input  logic [15:0]           flag,
    input  logic                  cr_load,
    input  logic [DW-1:0]         cr_din,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic                  taken,
    output logic [AW-1:0]         pc_o,
    output logic                  fault,
    output logic [DW-1:0]         cr_o,
    output logic [SPW-1:0]        sp_o
);

    function automatic logic eval_flags(input logic [JMP_TYPE_W-1:0] code,
                                        input logic [15:0] f);
        logic zf, cf, sf, of;
        logic res;
        zf  = f[ALUF_ZF];
        cf  = f[ALUF_CF];
        sf  = f[ALUF_SF];
        of  = f[ALUF_OF];
        res = 1'b0;
        case (code)
            JMP_FORCE: res = 1'b1;
            JMP_E:     res = zf;
            JMP_NE:    res = !zf;
            JMP_A:     res = !cf && !zf;
            JMP_AE:    res = !cf;
            JMP_B:     res = cf;
            JMP_BE:    res = cf || zf;
            JMP_G:     res = !zf && (sf == of);
            JMP_GE:    res = (sf == of);
            JMP_L:     res = (sf != of);
            JMP_LE:    res = zf || (sf != of);
            JMP_S:     res = sf;
            JMP_NS:    res = !sf;
            JMP_O:     res = of;
            JMP_NO:    res = !of;
            default:   res = 1'b0;
        endcase
        return res;
    endfunction

    out_state_e    state_q, state_n;
    logic          vld_p1;
    logic          taken_p1;
    logic          fault_p1;
    logic [AW-1:0] pc_p1;
    logic [DW-1:0] cr_q;

    logic          accept;
    logic          cond;
    logic          flt;
    logic [AW-1:0] pc_next;
    logic          cr_nz;
    logic          stk_push, stk_pop, stk_full, stk_empty;
    logic [AW-1:0] stk_dout;

    assign vld_p1    = (state_q == OUT_FULL);
    assign req_ready = !vld_p1 || resp_ready;
    assign accept    = req_valid && req_ready;
    assign cr_nz     = (cr_q != '0);

    // Stage 0: resolve condition, fault and next PC from the request and current state
    always_comb begin
        cond    = 1'b0;
        flt     = 1'b0;
        pc_next = pc_i;
        case (br_type)
            JMP_CRZ:  cond = !cr_nz;
            JMP_CRNZ: cond = cr_nz;
            JMP_LOOP: cond = cr_nz;
            JMP_CALL: begin
                cond = !stk_full;
                flt  = stk_full;
            end
            JMP_RET: begin
                cond = !stk_empty;
                flt  = stk_empty;
            end
            default: begin
                if (br_type <= JMP_NO) begin
                    cond = eval_flags(br_type, flag);
                end else begin
                    flt = 1'b1;
                end
            end
        endcase
        if (cond) begin
            pc_next = (br_type == JMP_RET) ? stk_dout : target;
        end
    end

    assign stk_push = accept && (br_type == JMP_CALL) && !stk_full;
    assign stk_pop  = accept && (br_type == JMP_RET) && !stk_empty;

    ret_stack #(
        .AW    (AW),
        .DEPTH (DEPTH)
    ) u_ret_stack (
        .clk   (clk),
        .rst   (rst),
        .push  (stk_push),
        .pop   (stk_pop),
        .din   (pc_i),
        .dout  (stk_dout),
        .full  (stk_full),
        .empty (stk_empty),
        .sp    (sp_o)
    );

    // A load in the same cycle as an accepted LOOP overrides the decrement.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cr_q <= '0;
        end else if (cr_load) begin
            cr_q <= cr_din;
        end else if (accept && (br_type == JMP_LOOP) && cr_nz) begin
            cr_q <= cr_q - DW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= OUT_EMPTY;
        end else begin
            state_q <= state_n;
        end
    end

    always_comb begin
        state_n = state_q;
        case (state_q)
            OUT_EMPTY: if (accept) state_n = OUT_FULL;
            OUT_FULL:  if (resp_ready && !accept) state_n = OUT_EMPTY;
            default:   state_n = OUT_EMPTY;
        endcase
    end

    // Stage 1: response register, reloaded only on accept so it holds under backpressure
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            taken_p1 <= 1'b0;
            fault_p1 <= 1'b0;
            pc_p1    <= '0;
        end else if (accept) begin
            taken_p1 <= cond;
            fault_p1 <= flt;
            pc_p1    <= pc_next;
        end
    end

    assign resp_valid = vld_p1;
    assign taken      = taken_p1;
    assign fault      = fault_p1;
    assign pc_o       = pc_p1;
    assign cr_o       = cr_q;

endmodule

// File: tb/tb_branch_unit.sv
// Directed bench for branch_unit: flag-sweep vector table plus loop, stack, backpressure and reset sequences.
module tb_branch_unit;
    import jmp_defs::*;

    localparam int AW = 16;
    localparam int DW = 16;
    localparam int DEPTH = 4;
    localparam int SPW = $clog2(DEPTH) + 1;

    localparam logic [15:0] M_Z = 16'h0040;
    localparam logic [15:0] M_C = 16'h0001;
    localparam logic [15:0] M_S = 16'h0080;
    localparam logic [15:0] M_O = 16'h0800;

    logic           clk = 1'b0;
    logic           rst;
    logic           req_valid;
    logic           req_ready;
    logic [4:0]     br_type;
    logic [AW-1:0]  target;
    logic [AW-1:0]  pc_i;
    logic [15:0]    flag;
    logic           cr_load;
    logic [DW-1:0]  cr_din;
    logic           resp_valid;
    logic           resp_ready;
    logic           taken;
    logic [AW-1:0]  pc_o;
    logic           fault;
    logic [DW-1:0]  cr_o;
    logic [SPW-1:0] sp_o;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    branch_unit #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .br_type    (br_type),
        .target     (target),
        .pc_i       (pc_i),
        .flag       (flag),
        .cr_load    (cr_load),
        .cr_din     (cr_din),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .taken      (taken),
        .pc_o       (pc_o),
        .fault      (fault),
        .cr_o       (cr_o),
        .sp_o       (sp_o)
    );

    typedef struct {
        logic [4:0]  code;
        logic [15:0] flg;
        logic        exp_taken;
    } vec_t;

    vec_t vecs[30];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Drive one request, clock it in, and return 1ns after the edge with the response visible.
    task automatic send(input logic [4:0] t, input logic [15:0] tgt, input logic [15:0] pc,
                        input logic [15:0] fl);
        br_type   = t;
        target    = tgt;
        pc_i      = pc;
        flag      = fl;
        req_valid = 1'b1;
        chk("req_ready_before_send", req_ready, 1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        cr_load   = 1'b0;
    endtask

    task automatic idle();
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        cr_load = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] exp_ret [4];
        logic        exp_lt [4];
        logic [15:0] exp_lc [4];

        vecs[0]  = '{JMP_FORCE, 16'h0000, 1'b1};
        vecs[1]  = '{JMP_FORCE, 16'hFFFF, 1'b1};
        vecs[2]  = '{JMP_E,  M_Z,       1'b1};
        vecs[3]  = '{JMP_E,  16'h0000,  1'b0};
        vecs[4]  = '{JMP_NE, 16'h0000,  1'b1};
        vecs[5]  = '{JMP_NE, M_Z,       1'b0};
        vecs[6]  = '{JMP_A,  16'h0000,  1'b1};
        vecs[7]  = '{JMP_A,  M_C,       1'b0};
        vecs[8]  = '{JMP_AE, M_Z,       1'b1};
        vecs[9]  = '{JMP_AE, M_C,       1'b0};
        vecs[10] = '{JMP_B,  M_C,       1'b1};
        vecs[11] = '{JMP_B,  16'h0000,  1'b0};
        vecs[12] = '{JMP_BE, M_Z,       1'b1};
        vecs[13] = '{JMP_BE, 16'h0000,  1'b0};
        vecs[14] = '{JMP_G,  M_S | M_O, 1'b1};
        vecs[15] = '{JMP_G,  M_Z,       1'b0};
        vecs[16] = '{JMP_GE, M_S | M_O, 1'b1};
        vecs[17] = '{JMP_GE, M_S,       1'b0};
        vecs[18] = '{JMP_L,  M_S,       1'b1};
        vecs[19] = '{JMP_L,  M_S | M_O, 1'b0};
        vecs[20] = '{JMP_LE, M_Z,       1'b1};
        vecs[21] = '{JMP_LE, 16'h0000,  1'b0};
        vecs[22] = '{JMP_S,  M_S,       1'b1};
        vecs[23] = '{JMP_S,  16'h0000,  1'b0};
        vecs[24] = '{JMP_NS, 16'h0000,  1'b1};
        vecs[25] = '{JMP_NS, M_S,       1'b0};
        vecs[26] = '{JMP_O,  M_O,       1'b1};
        vecs[27] = '{JMP_O,  16'h0000,  1'b0};
        vecs[28] = '{JMP_NO, 16'h0000,  1'b1};
        vecs[29] = '{JMP_NO, M_O,       1'b0};

        rst = 1'b1; req_valid = 1'b0; br_type = '0; target = '0; pc_i = '0;
        flag = '0; cr_load = 1'b0; cr_din = '0; resp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_taken", taken, 0);
        chk("rst_fault", fault, 0);
        chk("rst_pc_o", pc_o, 0);
        chk("rst_cr_o", cr_o, 0);
        chk("rst_sp_o", sp_o, 0);
        chk("rst_req_ready", req_ready, 1);

        // Flag sweep
        for (int i = 0; i < 30; i++) begin
            send(vecs[i].code, 16'h1234, 16'h0010, vecs[i].flg);
            chk($sformatf("sweep%0d_valid", i), resp_valid, 1);
            chk($sformatf("sweep%0d_taken", i), taken, vecs[i].exp_taken);
            chk($sformatf("sweep%0d_pc", i), pc_o, vecs[i].exp_taken ? 16'h1234 : 16'h0010);
            chk($sformatf("sweep%0d_fault", i), fault, 0);
        end

        // Count-register conditions with cr == 0
        send(JMP_CRZ, 16'h0A00, 16'h0020, 16'h0000);
        chk("crz_taken", taken, 1);
        chk("crz_pc", pc_o, 16'h0A00);
        send(JMP_CRNZ, 16'h0A00, 16'h0020, 16'h0000);
        chk("crnz_taken", taken, 0);
        chk("crnz_pc", pc_o, 16'h0020);

        // Loop: load 3, four back-to-back LOOPs
        cr_load = 1'b1; cr_din = 16'd3;
        idle();
        chk("loop_cr_loaded", cr_o, 3);
        exp_lt = '{1'b1, 1'b1, 1'b1, 1'b0};
        exp_lc = '{16'd2, 16'd1, 16'd0, 16'd0};
        for (int i = 0; i < 4; i++) begin
            send(JMP_LOOP, 16'h2000, 16'h0100, 16'h0000);
            chk($sformatf("loop%0d_valid", i), resp_valid, 1);
            chk($sformatf("loop%0d_taken", i), taken, exp_lt[i]);
            chk($sformatf("loop%0d_cr", i), cr_o, exp_lc[i]);
            chk($sformatf("loop%0d_pc", i), pc_o, exp_lt[i] ? 16'h2000 : 16'h0100);
        end

        // Call/return with overflow and underflow
        for (int i = 0; i < 5; i++) begin
            send(JMP_CALL, 16'h0800, 16'(16'h0010 * (i + 1)), 16'h0000);
            if (i < 4) begin
                chk($sformatf("call%0d_taken", i), taken, 1);
                chk($sformatf("call%0d_fault", i), fault, 0);
                chk($sformatf("call%0d_pc", i), pc_o, 16'h0800);
                chk($sformatf("call%0d_sp", i), sp_o, i + 1);
            end else begin
                chk("call_ovf_fault", fault, 1);
                chk("call_ovf_taken", taken, 0);
                chk("call_ovf_pc", pc_o, 16'h0050);
                chk("call_ovf_sp", sp_o, 4);
            end
        end
        exp_ret = '{16'h0040, 16'h0030, 16'h0020, 16'h0010};
        for (int i = 0; i < 4; i++) begin
            send(JMP_RET, 16'hDEAD, 16'h0099, 16'h0000);
            chk($sformatf("ret%0d_taken", i), taken, 1);
            chk($sformatf("ret%0d_fault", i), fault, 0);
            chk($sformatf("ret%0d_pc", i), pc_o, exp_ret[i]);
            chk($sformatf("ret%0d_sp", i), sp_o, 3 - i);
        end
        send(JMP_RET, 16'hDEAD, 16'h0099, 16'h0000);
        chk("ret_unf_fault", fault, 1);
        chk("ret_unf_taken", taken, 0);
        chk("ret_unf_pc", pc_o, 16'h0099);
        send(JMP_FORCE, 16'h0444, 16'h0010, 16'h0000);
        chk("fault_not_sticky", fault, 0);

        // Backpressure
        cr_load = 1'b1; cr_din = 16'd5;
        idle();
        resp_ready = 1'b0;
        send(JMP_LOOP, 16'h3000, 16'h0200, 16'h0000);
        chk("bp_first_taken", taken, 1);
        chk("bp_first_cr", cr_o, 4);
        br_type = JMP_LOOP; target = 16'h3100; pc_i = 16'h0300; req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("bp%0d_req_ready", i), req_ready, 0);
            chk($sformatf("bp%0d_valid", i), resp_valid, 1);
            chk($sformatf("bp%0d_pc", i), pc_o, 16'h3000);
            chk($sformatf("bp%0d_taken", i), taken, 1);
            chk($sformatf("bp%0d_cr", i), cr_o, 4);
            chk($sformatf("bp%0d_sp", i), sp_o, 0);
        end
        resp_ready = 1'b1;
        #1;
        chk("bp_release_ready", req_ready, 1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("bp_next_valid", resp_valid, 1);
        chk("bp_next_pc", pc_o, 16'h3100);
        chk("bp_next_cr", cr_o, 3);

        // Load/LOOP collision, then illegal code
        cr_load = 1'b1; cr_din = 16'd5;
        idle();
        chk("col_cr_pre", cr_o, 5);
        cr_load = 1'b1; cr_din = 16'd9;
        send(JMP_LOOP, 16'h4000, 16'h0400, 16'h0000);
        chk("col_taken", taken, 1);
        chk("col_pc", pc_o, 16'h4000);
        chk("col_cr", cr_o, 9);
        send(5'd25, 16'h5555, 16'h0444, 16'hFFFF);
        chk("ill_fault", fault, 1);
        chk("ill_taken", taken, 0);
        chk("ill_pc", pc_o, 16'h0444);
        chk("ill_cr", cr_o, 9);
        chk("ill_sp", sp_o, 0);

        // Asynchronous reset with a held response and two stack entries
        send(JMP_CALL, 16'h0600, 16'h0011, 16'h0000);
        send(JMP_CALL, 16'h0600, 16'h0022, 16'h0000);
        resp_ready = 1'b0;
        chk("prerst_sp", sp_o, 2);
        chk("prerst_valid", resp_valid, 1);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_valid", resp_valid, 0);
        chk("arst_cr", cr_o, 0);
        chk("arst_sp", sp_o, 0);
        chk("arst_pc", pc_o, 0);
        chk("arst_taken", taken, 0);
        #1;
        rst = 1'b0;
        resp_ready = 1'b1;
        send(JMP_RET, 16'h0777, 16'h0ABC, 16'h0000);
        chk("postrst_ret_fault", fault, 1);
        chk("postrst_ret_taken", taken, 0);
        chk("postrst_ret_pc", pc_o, 16'h0ABC);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
